divider_32bu: RTL and testbench

DIVIDER_32BU -- requirements
Module: divider_32bu

---
 rtl/divider_32bu.sv | 115 +++++++++++
 tb/tb_divider_32bu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/divider_32bu.sv
// divider_32bu: 32-bit unsigned restoring shift-subtract divider.
// One capture edge plus 32 RUN edges per division; q/r/divByZero are
// registered and change only when a division completes.
// Optional build macro DIVIDER_32BU_DIV0_EN: a zero divisor skips RUN,
// loads q=all-ones, r=a, raises divByZero and goes straight to DONE.
module divider_32bu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        finish,
    output logic        divByZero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] cnt;
    logic [W:0]    rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvs;

    logic          accept_c;
    logic          fast_c;
    logic          last_c;
    logic [W:0]    rem_sh_c;
    logic [W:0]    diff_c;
    logic [W:0]    rem_nx_c;
    logic [W-1:0]  quo_nx_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic; start is honoured only outside RUN
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        fast_c     = 1'b0;
        last_c     = (cnt == CW'(W - 1));
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept_c = 1'b1;
`ifdef DIVIDER_32BU_DIV0_EN
                    fast_c = (b == '0);
`else
                    fast_c = 1'b0;
`endif
                    state_next = fast_c ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_c) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: shift, trial-subtract, keep result if non-negative
    always_comb begin
        rem_sh_c = {rem[W-1:0], quo[W-1]};
        diff_c   = rem_sh_c - {1'b0, dvs};
        rem_nx_c = diff_c[W] ? rem_sh_c : diff_c;
        quo_nx_c = {quo[W-2:0], ~diff_c[W]};
    end

    // Datapath and registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            q         <= '0;
            r         <= '0;
            finish    <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            finish <= (state_next == DONE);
            if (accept_c) begin
                dvs <= b;
                rem <= '0;
                quo <= a;
                cnt <= '0;
                if (fast_c) begin
                    q         <= '1;
                    r         <= a;
                    divByZero <= 1'b1;
                end
            end else if (state == RUN) begin
                rem <= rem_nx_c;
                quo <= quo_nx_c;
                cnt <= cnt + CW'(1);
                if (last_c) begin
                    q         <= quo_nx_c;
                    r         <= rem_nx_c[W-1:0];
                    divByZero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_32bu.sv
// Directed self-checking bench for divider_32bu.
module tb_divider_32bu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        finish;
    logic        divByZero;

    int checks   = 0;
    int failures = 0;

`ifdef DIVIDER_32BU_DIV0_EN
    localparam int  DZ_LAT = 0;
    localparam logic DZ_FLAG = 1'b1;
`else
    localparam int  DZ_LAT = 32;
    localparam logic DZ_FLAG = 1'b0;
`endif

    divider_32bu dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .q         (q),
        .r         (r),
        .finish    (finish),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one division, wait for finish (bounded), check latency/hold/results
    task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int lat, input bit chk_hold);
        logic [31:0] q0;
        logic [31:0] r0;
        int n;
        bit held_bad;
        q0 = q;
        r0 = r;
        held_bad = 0;
        start = 1'b1;
        a = av;
        b = bv;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        while (finish !== 1'b1 && n < 100) begin
            if (q !== q0 || r !== r0) held_bad = 1;
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        if (chk_hold) check({tag, "_hold"}, 32'(held_bad), 32'd0);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_dz"}, 32'(divByZero), 32'(edz));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int n;
        bit seen;

        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_dz", 32'(divByZero), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("idle_finish", 32'(finish), 32'd0);

        // Basic case, also checks results hold through RUN
        do_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1);
        do_div("dmax_1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 32, 1);
        do_div("d5_10", 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 32, 1);
        do_div("dmsb", 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 32, 1);
        do_div("dz", 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, DZ_FLAG, DZ_LAT, 0);
        // Flag must clear again on the next nonzero division
        do_div("after_dz", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32, 1);

        // Start during RUN is ignored
        start = 1'b1;
        a = 32'd100;
        b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        start = 1'b1;
        a = 32'd9;
        b = 32'd3;
        tick();
        start = 1'b0;
        n = 11;
        while (finish !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("restart_lat", 32'(n), 32'd32);
        check("restart_q", q, 32'd14);
        check("restart_r", r, 32'd2);

        // Reset mid-RUN clears outputs without a clock edge
        start = 1'b1;
        a = 32'd100;
        b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("mrst_q", q, 32'd0);
        check("mrst_r", r, 32'd0);
        check("mrst_finish", 32'(finish), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (finish === 1'b1) seen = 1;
        end
        check("mrst_idle", 32'(seen), 32'd0);
        do_div("d50_6", 32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 32, 1);

        // Back-to-back pseudo-random divisions started from DONE
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            do_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 32, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
